// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Purpose  : Shared types and helpers for the round-robin arbiter system.
//             Holds the requester-agent FSM state type, the FIFO occupancy
//             width helper and the system-level arbiter port count.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Number of requester ports on the system arbiter (one agent per port).
    localparam int unsigned c_arb_ports = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } agent_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO with registered occupancy count.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             push, push_data - write request and payload (ignored if full)
//             pop, pop_data   - read request (ignored if empty), head entry
//             full, empty     - status from the registered count
//             count           - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = count_width(DEPTH);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_full_cnt);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Guard internally so a misbehaving caller cannot corrupt the pointers.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/arb_req_agent.sv
`default_nettype none
// ============================================================================
//  Module   : arb_req_agent
//  Purpose  : Requester-side agent for one port of the round-robin arbiter.
//             Buffers transactions, raises req, forwards one transaction per
//             registered grant pulse and flags starvation / spurious grants.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_valid/in_ready/in_data - upstream push interface
//             req, grant          - arbiter handshake for this port
//             out_valid, out_data - registered payload to shared resource
//             count               - FIFO occupancy
//             starve, drop_err    - sticky status flags
//  Revision : 1.0 - initial release
// ============================================================================
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   req,
    input  logic                   grant,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   starve,
    output logic                   drop_err
);

    localparam int c_wait_w = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(TIMEOUT);

    agent_state_e        r_state;
    agent_state_e        w_state_nxt;
    logic [c_wait_w-1:0] r_wait;
    logic [c_wait_w-1:0] w_wait_inc;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [DATA_W-1:0]   w_head;

    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;
    // Pops only happen in REQ, so a same-cycle push into an empty FIFO is safe.
    assign w_pop    = (r_state == ST_REQ) & grant & ~w_empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (count)
    );

    always_comb begin
        w_state_nxt = r_state;
        req         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty || w_push) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                req = 1'b1;
                if (w_pop) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                // count already reflects the pop taken on the way in
                w_state_nxt = w_empty ? ST_IDLE : ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wait_inc = (r_wait == c_wait_max) ? c_wait_max : r_wait + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= '0;
            starve    <= 1'b0;
            drop_err  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            out_valid <= w_pop;
            if (w_pop) out_data <= w_head;

            if (r_state != ST_REQ && w_state_nxt == ST_REQ) begin
                r_wait <= '0;
            end else if (r_state == ST_REQ) begin
                r_wait <= w_wait_inc;
            end

            // Flag the edge on which the count reaches TIMEOUT inside REQ.
            if (r_state == ST_REQ && w_wait_inc == c_wait_max) starve <= 1'b1;
            if (grant && r_state != ST_REQ) drop_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_req_agent.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_req_agent
//  Purpose  : Self-checking bench for arb_req_agent with a queue-based
//             reference model and directed scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_req_agent;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    // model phase names
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_GAP  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              grant = 1'b0;
    logic              in_ready;
    logic              req;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     count;
    logic              starve;
    logic              drop_err;

    always #5 clk = ~clk;

    arb_req_agent #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .count     (count),
        .starve    (starve),
        .drop_err  (drop_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mq[$];
    int                ph = P_IDLE;
    int                mwait = 0;
    bit                mstarve = 0;
    bit                mdrop = 0;
    bit                mov = 0;
    logic [DATA_W-1:0] mod = '0;
    bit                model_on = 0;

    // Apply inputs for one cycle, advance the model across the edge, return
    // just after the following falling edge.
    task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit g, input bit r);
        bit push;
        bit pop;
        int nph;
        in_valid = v;
        in_data  = d;
        grant    = g;
        rst      = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            ph = P_IDLE; mwait = 0; mstarve = 0; mdrop = 0; mov = 0; mod = '0;
            model_on = 1;
        end else begin
            push = v && (mq.size() < DEPTH);
            pop  = (ph == P_REQ) && g && (mq.size() != 0);
            if (g && ph != P_REQ) mdrop = 1;
            mov = pop;
            if (pop) mod = mq[0];
            case (ph)
                P_IDLE:  nph = (mq.size() != 0 || push) ? P_REQ : P_IDLE;
                P_REQ:   nph = pop ? P_GAP : P_REQ;
                default: nph = (mq.size() != 0) ? P_REQ : P_IDLE;
            endcase
            if (ph == P_REQ) begin
                mwait = (mwait < TIMEOUT) ? mwait + 1 : TIMEOUT;
                if (mwait == TIMEOUT) mstarve = 1;
            end
            if (ph != P_REQ && nph == P_REQ) mwait = 0;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(d);
            ph = nph;
        end
        @(negedge clk);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            chk("req",       req,       (ph == P_REQ));
            chk("in_ready",  in_ready,  (mq.size() < DEPTH));
            chk("count",     count,     mq.size());
            chk("out_valid", out_valid, mov);
            chk("out_data",  out_data,  mod);
            chk("starve",    starve,    mstarve);
            chk("drop_err",  drop_err,  mdrop);
        end
    end

    // Grant on alternate REQ cycles (starting with a grant), collect outputs.
    logic [DATA_W-1:0] seen[$];

    task automatic drain_alt(input int max_cycles);
        bit alt;
        bit g;
        alt = 1;
        for (int i = 0; i < max_cycles; i++) begin
            g = 0;
            if (ph == P_REQ) begin
                g = alt;
                alt = ~alt;
            end
            tick(0, '0, g, 0);
            if (out_valid === 1'b1) seen.push_back(out_data);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] exp_v;

        tick(0, '0, 0, 1);
        tick(0, '0, 0, 1);
        chk("rst_count", count, 0);
        chk("rst_req", req, 0);
        chk("rst_out_valid", out_valid, 0);

        // single transaction
        tick(1, 32'hA5, 0, 0);
        chk("single_req_c1", req, 1);
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);
        tick(0, '0, 1, 0);
        chk("single_ov", out_valid, 1);
        chk("single_od", out_data, 32'hA5);
        chk("single_gap_req", req, 0);
        tick(0, '0, 0, 0);
        chk("single_idle_req", req, 0);
        chk("single_count", count, 0);
        chk("single_ov_once", out_valid, 0);
        tick(0, '0, 0, 0);

        // fill and drain
        for (int i = 1; i <= 4; i++) tick(1, DATA_W'(i), 0, 0);
        chk("full_ready", in_ready, 0);
        chk("full_count", count, 4);
        tick(1, 32'h5, 0, 0);
        chk("full_no_overwrite", count, 4);
        seen.delete();
        drain_alt(16);
        chk("drain_n", seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp_v = DATA_W'(i + 1);
            chk("drain_order", seen[i], exp_v);
        end
        chk("drain_count", count, 0);

        // simultaneous push and pop
        tick(1, 32'h11, 0, 0);
        tick(1, 32'h22, 0, 0);
        chk("simul_pre_count", count, 2);
        tick(1, 32'h7, 1, 0);
        chk("simul_count", count, 2);
        chk("simul_od", out_data, 32'h11);
        seen.delete();
        drain_alt(12);
        chk("simul_n", seen.size(), 2);
        chk("simul_mid", seen[0], 32'h22);
        chk("simul_last", seen[1], 32'h7);

        // spurious grant in IDLE
        tick(0, '0, 1, 0);
        chk("spur_idle_drop", drop_err, 1);
        chk("spur_idle_ov", out_valid, 0);
        chk("spur_idle_count", count, 0);
        // spurious grant in GAP
        tick(1, 32'h33, 0, 0);
        tick(0, '0, 1, 0);
        chk("spur_real_od", out_data, 32'h33);
        tick(0, '0, 1, 0);
        chk("spur_gap_ov", out_valid, 0);
        chk("spur_gap_count", count, 0);
        chk("spur_gap_drop", drop_err, 1);
        tick(0, '0, 0, 0);

        // starvation
        tick(1, 32'h55, 0, 0);
        repeat (7) tick(0, '0, 0, 0);
        chk("starve_before", starve, 0);
        tick(0, '0, 0, 0);
        chk("starve_set", starve, 1);
        tick(0, '0, 1, 0);
        chk("starve_ov", out_valid, 1);
        chk("starve_od", out_data, 32'h55);
        chk("starve_held", starve, 1);
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);

        // reset mid-operation, grant coincident with reset
        tick(1, 32'hA, 0, 0);
        tick(1, 32'hB, 0, 0);
        tick(1, 32'hC, 0, 0);
        chk("mid_pre_count", count, 3);
        chk("mid_pre_req", req, 1);
        tick(0, '0, 1, 1);
        chk("mid_count", count, 0);
        chk("mid_req", req, 0);
        chk("mid_ov", out_valid, 0);
        chk("mid_starve", starve, 0);
        chk("mid_drop", drop_err, 0);
        tick(0, '0, 1, 0);
        chk("post_rst_drop", drop_err, 1);
        chk("post_rst_ov", out_valid, 0);
        tick(0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
